// File: rtl/oh_fifo_sync_prog.sv
// ---------------------------------------------------------------------------
// oh_fifo_sync_prog
//   Single-clock FIFO with programmable full/empty thresholds, sticky
//   overflow/underflow flags and a selectable read mode:
//     FWFT = 0 : standard mode, dout is registered and updates one cycle
//                after an accepted read, otherwise it holds.
//     FWFT = 1 : first-word-fall-through, dout always shows the head entry
//                while the FIFO is non-empty (zero otherwise).
//
// Ports
//   clk        sole clock, all state updates on the rising edge
//   nreset     asynchronous active-low reset
//   clear      synchronous flush, overrides wr_en/rd_en
//   wr_en/din  write request and data
//   rd_en      read request (FWFT=1: pop of the head entry)
//   dout       read data
//   full       count == DEPTH
//   empty      count == 0
//   prog_full  count >= PROG_FULL
//   prog_empty count <= PROG_EMPTY
//   count      number of valid entries (the entry shown on dout included)
//   overflow   sticky, write attempted while full
//   underflow  sticky, read attempted while empty
// ---------------------------------------------------------------------------
module oh_fifo_sync_prog #(
  parameter int DW         = 104,
  parameter int DEPTH      = 32,
  parameter int PROG_FULL  = DEPTH / 2,
  parameter int PROG_EMPTY = 2,
  parameter int FWFT       = 0,
  parameter int CW         = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          prog_full,
  output logic          prog_empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] PFULL_CNT = CW'(PROG_FULL);
  localparam logic [CW-1:0] PEMPT_CNT = CW'(PROG_EMPTY);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  // Status flags come only from the registered count, so no input reaches
  // an output combinationally.
  always_comb begin
    empty      = (count == '0);
    full       = (count == FULL_CNT);
    prog_full  = (count >= PFULL_CNT);
    prog_empty = (count <= PEMPT_CNT);
    wr_ok      = wr_en & ~full  & ~clear;
    rd_ok      = rd_en & ~empty & ~clear;
  end

  // Storage array is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is always visible; a write into an empty FIFO lands at
      // rd_ptr, so it appears on dout the cycle after it is written.
      always_comb begin
        dout = empty ? '0 : mem[rd_ptr];
      end
    end else begin : g_std
      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)    dout <= '0;
        else if (clear) dout <= '0;
        else if (rd_ok) dout <= mem[rd_ptr];
      end
    end
  endgenerate

endmodule

// File: doc/oh_fifo_sync_prog.md
OH_FIFO_SYNC_PROG -- requirements
Module: oh_fifo_sync_prog

Interface
REQ-001 Parameter DW, default 104, data width in bits (>=1).
REQ-002 Parameter DEPTH, default 32, entries; power of 2, >=4.
REQ-003 Parameter PROG_FULL, default DEPTH/2, prog_full threshold (1..DEPTH).
REQ-004 Parameter PROG_EMPTY, default 2, prog_empty threshold (0..DEPTH-1).
REQ-005 Parameter FWFT, default 0; 0 = standard read mode, 1 = first-word-fall-through.
REQ-006 Parameter CW, default $clog2(DEPTH)+1, count width (represents 0..DEPTH).
REQ-007 Clocking/reset: one clock; reset is asynchronous and active-low; ports clk and nreset.
REQ-008 clk  input  1  sole clock, all state on rising edge.
REQ-009 nreset  input  1  asynchronous active-low reset.
REQ-010 clear  input  1  synchronous flush.
REQ-011 wr_en  input  1  write request.
REQ-012 din  input  DW  write data.
REQ-013 rd_en  input  1  read request (FWFT=1: pop of head).
REQ-014 dout  output  DW  read data.
REQ-015 full  output  1  count == DEPTH.
REQ-016 empty  output  1  no readable entry.
REQ-017 prog_full  output  1  count >= PROG_FULL.
REQ-018 prog_empty  output  1  count <= PROG_EMPTY.
REQ-019 count  output  CW  valid entries held.
REQ-020 overflow  output  1  sticky: write attempted while full.
REQ-021 underflow  output  1  sticky: read attempted while empty.

Function
REQ-022 Write accepted iff wr_en & ~full & ~clear; data stored in order.
REQ-023 Read accepted iff rd_en & ~empty & ~clear.
REQ-024 Write while full SHALL be dropped, contents unchanged, overflow set next cycle, even if a read is accepted that cycle.
REQ-025 Read while empty SHALL change nothing except underflow set next cycle; a same-cycle write is still accepted.
REQ-026 count: +1 write only, -1 read only, unchanged for both or neither; never exceeds DEPTH or goes below 0.
REQ-027 Pointers SHALL wrap modulo DEPTH with no lost or duplicated entry.
REQ-028 full, prog_full, prog_empty SHALL be derived from registered count only (no input-to-output comb path).
REQ-029 FWFT=0: empty = (count==0); accepted read at cycle N presents head on dout at N+1; dout otherwise holds.
REQ-030 FWFT=0: write at N into empty FIFO -> empty low at N+1; earliest data on dout at N+2.
REQ-031 FWFT=1: when ~empty, dout SHALL already show head entry; accepted read at N shows next entry (or empty=1) at N+1.
REQ-032 FWFT=1: write at N into empty FIFO -> empty low and dout=that din at N+1.
REQ-033 FWFT=1: count includes the entry shown on dout; empty = (count==0).
REQ-034 clear SHALL take priority over wr_en/rd_en: next cycle count=0, empty=1, full=0, overflow=underflow=0, dout=0; no error flags set by that cycle's requests.
REQ-035 Simultaneous accepted read and write at count=1 (FWFT=1): dout shows new entry next cycle, empty stays 0.

Reset
REQ-036 nreset low SHALL immediately, independent of clk, force count=0, empty=1, full=0, prog_empty=1, prog_full=0, overflow=0, underflow=0, dout=0, pointers=0.
REQ-037 Reset mid-operation SHALL discard all contents; first post-reset write behaves as into empty FIFO.
REQ-038 Memory array need not be reset.

Verification
REQ-039 DEPTH=32, FWFT=0: 32 writes 0..31 -> full=1, count=32, prog_full=1 from count 16; 33rd write -> overflow=1, count=32; 32 reads -> dout 0..31 in order, each one cycle after rd_en.
REQ-040 FWFT=1: single write 0xA5 at N -> empty=0, dout=0xA5 at N+1; rd_en at N+1 -> empty=1, count=0 at N+2.
REQ-041 Read while empty with write same cycle -> underflow=1, count=1, written data read back correctly.
REQ-042 Full FIFO, wr_en&rd_en together -> head popped, write dropped, overflow=1, count=31; 200 random push/pop cycles with count near wrap -> scoreboard matches order, no loss.
REQ-043 count=10 with overflow set, clear&wr_en&rd_en -> next cycle count=0, empty=1, overflow=0, underflow=0.
REQ-044 nreset asserted between clock edges with count=5 -> outputs at reset values before next clk edge; post-release write/read returns new data only.
